// File: rtl/multi_cycle_arithmetic_unit_pkg.sv
// Shared opcode encodings, FSM state encoding and opcode-class helpers for the
// multi-cycle arithmetic unit and its serial multiply/divide datapath.
package multi_cycle_arithmetic_unit_pkg;

    // Base ops keep their original 4-bit values, zero-extended to 5 bits.
    localparam logic [4:0] ALU_OP_ADD     = 5'h00;
    localparam logic [4:0] ALU_OP_SUB     = 5'h01;
    localparam logic [4:0] ALU_OP_AND     = 5'h02;
    localparam logic [4:0] ALU_OP_OR      = 5'h03;
    localparam logic [4:0] ALU_OP_XOR     = 5'h04;
    localparam logic [4:0] ALU_OP_SLL     = 5'h05;
    localparam logic [4:0] ALU_OP_SRL     = 5'h06;
    localparam logic [4:0] ALU_OP_SRA     = 5'h07;
    localparam logic [4:0] ALU_OP_UNKNOWN = 5'h0F;
    localparam logic [4:0] ALU_OP_SLT     = 5'h08;
    localparam logic [4:0] ALU_OP_SLTU    = 5'h09;
    localparam logic [4:0] ALU_OP_MUL     = 5'h10;
    localparam logic [4:0] ALU_OP_MULH    = 5'h11;
    localparam logic [4:0] ALU_OP_MULHSU  = 5'h12;
    localparam logic [4:0] ALU_OP_MULHU   = 5'h13;
    localparam logic [4:0] ALU_OP_DIV     = 5'h14;
    localparam logic [4:0] ALU_OP_DIVU    = 5'h15;
    localparam logic [4:0] ALU_OP_REM     = 5'h16;
    localparam logic [4:0] ALU_OP_REMU    = 5'h17;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_MUL  = 2'd1;
    localparam logic [1:0] STATE_DIV  = 2'd2;
    localparam logic [1:0] STATE_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_MUL  = STATE_MUL,
        ST_DIV  = STATE_DIV,
        ST_DONE = STATE_DONE
    } state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU};
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return op inside {ALU_OP_REM, ALU_OP_REMU};
    endfunction

    function automatic logic is_signed_div(input logic [4:0] op);
        return op inside {ALU_OP_DIV, ALU_OP_REM};
    endfunction

    function automatic logic op_a_signed(input logic [4:0] op);
        return op inside {ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_DIV, ALU_OP_REM};
    endfunction

    function automatic logic op_b_signed(input logic [4:0] op);
        return op inside {ALU_OP_MULH, ALU_OP_DIV, ALU_OP_REM};
    endfunction

    // High product half for MULH*, remainder for REM*.
    function automatic logic op_sel_alt(input logic [4:0] op);
        return op inside {ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU, ALU_OP_REM, ALU_OP_REMU};
    endfunction

endpackage

// File: rtl/multi_cycle_arithmetic_unit_serial_mul_div_datapath.sv
// Serial radix-2 multiply / restoring divide on operand magnitudes.
// Ports: i_Clock, i_Reset (async, active-high), i_Start loads operands and opcode,
// o_Done is high during the final iteration, o_Result is the sign-fixed result
// of that final iteration (valid only while o_Done is high).
module multi_cycle_arithmetic_unit_serial_mul_div_datapath
    import multi_cycle_arithmetic_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Start,
    input  logic [4:0]      i_Op,
    input  logic [XLEN-1:0] i_A,
    input  logic [XLEN-1:0] i_B,
    output logic            o_Done,
    output logic [XLEN-1:0] o_Result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_operand;
    logic              r_is_div;
    logic              r_sel_alt;
    logic              r_neg_main;
    logic              r_neg_rem;

    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_next, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem;

    assign w_a_neg = op_a_signed(i_Op) & i_A[XLEN-1];
    assign w_b_neg = op_b_signed(i_Op) & i_B[XLEN-1];
    assign w_a_mag = w_a_neg ? -i_A : i_A;
    assign w_b_mag = w_b_neg ? -i_B : i_B;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift right keeping the carry.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Restoring step: partial remainder is always < divisor, so the shifted
    // value fits XLEN+1 bits and the borrow bit decides the quotient bit.
    assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_shift - {1'b0, r_operand};
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    assign w_next = r_is_div ? w_div_next : w_mul_next;
    assign w_prod = r_neg_main ? -w_next : w_next;
    assign w_quot = r_neg_main ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];

    always_comb begin
        o_Result = '0;
        if (r_is_div)
            o_Result = r_sel_alt ? w_rem : w_quot;
        else
            o_Result = r_sel_alt ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    end

    assign o_Done = (r_count == CW'(1));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_is_div   <= 1'b0;
            r_sel_alt  <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else if (i_Start) begin
            r_count    <= CW'(XLEN);
            r_acc      <= {{XLEN{1'b0}}, w_a_mag};
            r_operand  <= w_b_mag;
            r_is_div   <= is_div_op(i_Op);
            r_sel_alt  <= op_sel_alt(i_Op);
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
            r_acc   <= w_next;
        end
    end

endmodule

// File: rtl/multi_cycle_arithmetic_unit.sv
// Execute-stage ALU: single-cycle RV32I ops plus serial RV32M mul/div/rem.
// Ports: i_Clock, i_Reset (async, active-high); request i_Valid/o_Ready with
// i_Alu_Select, i_Input_A, i_Input_B; result o_Result_Valid/i_Result_Ready with
// o_Alu_Result; o_Busy marks a serial op in flight.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | serial multiply iterating
// DIV   | serial divide iterating
// DONE  | result held until consumer takes it
module multi_cycle_arithmetic_unit #(
    parameter int XLEN        = 32,
    parameter int SHAMT_WIDTH = $clog2(XLEN),
    parameter bit ENABLE_M    = 1'b1
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Valid,
    output logic            o_Ready,
    input  logic [4:0]      i_Alu_Select,
    input  logic [XLEN-1:0] i_Input_A,
    input  logic [XLEN-1:0] i_Input_B,
    output logic            o_Result_Valid,
    input  logic            i_Result_Ready,
    output logic [XLEN-1:0] o_Alu_Result,
    output logic            o_Busy
);
    import multi_cycle_arithmetic_unit_pkg::*;

    state_t          r_state;
    logic            r_ready, r_valid, r_busy;
    logic [XLEN-1:0] r_result;

    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic            w_b_zero, w_overflow, w_special, w_serial, w_accept;
    logic            w_dp_done;
    logic [XLEN-1:0] w_dp_result, w_quick, w_special_result;

    assign w_shamt    = i_Input_B[SHAMT_WIDTH-1:0];
    assign w_b_zero   = (i_Input_B == '0);
    assign w_overflow = is_signed_div(i_Alu_Select)
                        && (i_Input_A == {1'b1, {(XLEN-1){1'b0}}}) && (i_Input_B == '1);
    assign w_special  = ENABLE_M && is_div_op(i_Alu_Select) && (w_b_zero || w_overflow);
    assign w_serial   = ENABLE_M && (is_mul_op(i_Alu_Select) || is_div_op(i_Alu_Select))
                        && !w_special;
    assign w_accept   = (r_state == ST_IDLE) && i_Valid;

    // Divide by zero wins over overflow; REM of overflow is 0, DIV of it is A.
    always_comb begin
        w_special_result = '0;
        if (is_rem_op(i_Alu_Select))
            w_special_result = w_b_zero ? i_Input_A : '0;
        else
            w_special_result = w_b_zero ? '1 : i_Input_A;
    end

    always_comb begin
        w_quick = '0;
        case (i_Alu_Select)
            ALU_OP_ADD:  w_quick = i_Input_A + i_Input_B;
            ALU_OP_SUB:  w_quick = i_Input_A - i_Input_B;
            ALU_OP_AND:  w_quick = i_Input_A & i_Input_B;
            ALU_OP_OR:   w_quick = i_Input_A | i_Input_B;
            ALU_OP_XOR:  w_quick = i_Input_A ^ i_Input_B;
            ALU_OP_SLL:  w_quick = i_Input_A << w_shamt;
            ALU_OP_SRL:  w_quick = i_Input_A >> w_shamt;
            ALU_OP_SRA:  w_quick = $signed(i_Input_A) >>> w_shamt;
            ALU_OP_SLT:  w_quick = {{(XLEN-1){1'b0}}, $signed(i_Input_A) < $signed(i_Input_B)};
            ALU_OP_SLTU: w_quick = {{(XLEN-1){1'b0}}, i_Input_A < i_Input_B};
            default:     w_quick = '0;
        endcase
        if (w_special)
            w_quick = w_special_result;
    end

    multi_cycle_arithmetic_unit_serial_mul_div_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Start  (w_accept && w_serial),
        .i_Op     (i_Alu_Select),
        .i_A      (i_Input_A),
        .i_B      (i_Input_B),
        .o_Done   (w_dp_done),
        .o_Result (w_dp_result)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (w_serial) begin
                            r_state <= is_div_op(i_Alu_Select) ? ST_DIV : ST_MUL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_quick;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_dp_done) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= w_dp_result;
                    end
                end
                ST_DONE: begin
                    if (i_Result_Ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_Ready        = r_ready;
    assign o_Result_Valid = r_valid;
    assign o_Alu_Result   = r_result;
    assign o_Busy         = r_busy;

endmodule

// File: tb/tb_multi_cycle_arithmetic_unit.sv
module tb_multi_cycle_arithmetic_unit;
    import multi_cycle_arithmetic_unit_pkg::*;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [4:0]  i_Alu_Select = '0;
    logic [31:0] i_Input_A = '0;
    logic [31:0] i_Input_B = '0;
    logic        o_Result_Valid;
    logic        i_Result_Ready = 1'b0;
    logic [31:0] o_Alu_Result;
    logic        o_Busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_Clock = ~i_Clock;

    multi_cycle_arithmetic_unit dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Valid        (i_Valid),
        .o_Ready        (o_Ready),
        .i_Alu_Select   (i_Alu_Select),
        .i_Input_A      (i_Input_A),
        .i_Input_B      (i_Input_B),
        .o_Result_Valid (o_Result_Valid),
        .i_Result_Ready (i_Result_Ready),
        .o_Alu_Result   (o_Alu_Result),
        .o_Busy         (o_Busy)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic straight from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (op)
            ALU_OP_ADD:    return a + b;
            ALU_OP_SUB:    return a - b;
            ALU_OP_AND:    return a & b;
            ALU_OP_OR:     return a | b;
            ALU_OP_XOR:    return a ^ b;
            ALU_OP_SLL:    return a << b[4:0];
            ALU_OP_SRL:    return a >> b[4:0];
            ALU_OP_SRA:    return $signed(a) >>> b[4:0];
            ALU_OP_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
            ALU_OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_OP_MUL:    begin p = ua * ub; return p[31:0]; end
            ALU_OP_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ALU_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            ALU_OP_REM: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            ALU_OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_OP_REMU:   return (b == 0) ? a : a % b;
            default:       return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit signed_div;
        signed_div = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
        if (op inside {ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU}) return 33;
        if (op inside {ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU}) begin
            if (b == 0) return 1;
            if (signed_div && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // Called at a falling edge; returns at a falling edge after the result is taken.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!o_Ready && guard < 100) begin
            @(negedge i_Clock);
            guard++;
        end
        i_Valid        = 1'b1;
        i_Alu_Select   = op;
        i_Input_A      = a;
        i_Input_B      = b;
        i_Result_Ready = 1'b0;
        @(posedge i_Clock);
        #1;
        i_Valid      = 1'b0;
        i_Alu_Select = 5'($urandom);
        i_Input_A    = $urandom;
        i_Input_B    = $urandom;
        lat = 1;
        while (!o_Result_Valid && lat < 100) begin
            @(posedge i_Clock);
            #1;
            lat++;
        end
        res = o_Alu_Result;
        @(negedge i_Clock);
        i_Result_Ready = 1'b1;
        @(posedge i_Clock);
        #1;
        i_Result_Ready = 1'b0;
        @(negedge i_Clock);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] op_list[19] = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
                                ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU,
                                ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
                                ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
                                ALU_OP_UNKNOWN};

    initial begin
        logic [31:0] res;
        int          lat;
        int          guard;

        vecs.push_back('{"add_wrap",  ALU_OP_ADD,    32'hFFFF_FFFF, 32'h1,         32'h0,         1});
        vecs.push_back('{"sub",       ALU_OP_SUB,    32'd5,         32'd7,         32'hFFFF_FFFE, 1});
        vecs.push_back('{"and",       ALU_OP_AND,    32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1});
        vecs.push_back('{"or",        ALU_OP_OR,     32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1});
        vecs.push_back('{"xor",       ALU_OP_XOR,    32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1});
        vecs.push_back('{"sll_shamt", ALU_OP_SLL,    32'h1,         32'h21,        32'h2,         1});
        vecs.push_back('{"srl",       ALU_OP_SRL,    32'h8000_0000, 32'h4,         32'h0800_0000, 1});
        vecs.push_back('{"sra",       ALU_OP_SRA,    32'h8000_0000, 32'h24,        32'hF800_0000, 1});
        vecs.push_back('{"slt",       ALU_OP_SLT,    32'hFFFF_FFFF, 32'h1,         32'h1,         1});
        vecs.push_back('{"sltu",      ALU_OP_SLTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         1});
        vecs.push_back('{"unknown",   ALU_OP_UNKNOWN,32'd5,         32'd6,         32'h0,         1});
        vecs.push_back('{"unknown1f", 5'h1F,         32'd5,         32'd6,         32'h0,         1});
        vecs.push_back('{"mulh_min",  ALU_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{"mulhsu",    ALU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{"mul_neg",   ALU_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{"mulhu",     ALU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{"div_neg",   ALU_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{"rem_neg",   ALU_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{"divu",      ALU_OP_DIVU,   32'd100,       32'd7,         32'd14,        33});
        vecs.push_back('{"remu",      ALU_OP_REMU,   32'd100,       32'd7,         32'd2,         33});
        vecs.push_back('{"div_by0",   ALU_OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"rem_by0",   ALU_OP_REM,    32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{"div_ovf",   ALU_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"rem_ovf",   ALU_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{"divu_by0",  ALU_OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"remu_by0",  ALU_OP_REMU,   32'd9,         32'd0,         32'd9,         1});
        vecs.push_back('{"divu_big",  ALU_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33});
        vecs.push_back('{"remu_big",  ALU_OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});

        // Reset state
        repeat (2) @(negedge i_Clock);
        check("rst_ready", {31'b0, o_Ready}, 32'd1);
        check("rst_valid", {31'b0, o_Result_Valid}, 32'd0);
        check("rst_result", o_Alu_Result, 32'd0);
        check("rst_busy", {31'b0, o_Busy}, 32'd0);
        i_Reset = 1'b0;
        @(negedge i_Clock);

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Reset in the middle of a multiply, after a nonzero result is registered
        do_op(ALU_OP_ADD, 32'd3, 32'd4, res, lat);
        check("pre_rst_add", res, 32'd7);
        i_Valid = 1'b1; i_Alu_Select = ALU_OP_MUL; i_Input_A = 32'd7; i_Input_B = 32'd3;
        @(posedge i_Clock);
        #1;
        i_Valid = 1'b0;
        check("mul_busy", {31'b0, o_Busy}, 32'd1);
        check("mul_not_ready", {31'b0, o_Ready}, 32'd0);
        repeat (5) @(posedge i_Clock);
        #1;
        i_Reset = 1'b1;
        #1;
        check("midrst_ready", {31'b0, o_Ready}, 32'd1);
        check("midrst_valid", {31'b0, o_Result_Valid}, 32'd0);
        check("midrst_result", o_Alu_Result, 32'd0);
        check("midrst_busy", {31'b0, o_Busy}, 32'd0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(negedge i_Clock);
        do_op(ALU_OP_ADD, 32'd10, 32'd20, res, lat);
        check("post_rst_add", res, 32'd30);
        check("post_rst_lat", 32'(lat), 32'd1);

        // Backpressure on a completed DIVU
        i_Valid = 1'b1; i_Alu_Select = ALU_OP_DIVU; i_Input_A = 32'd100; i_Input_B = 32'd7;
        @(posedge i_Clock);
        #1;
        i_Valid = 1'b0;
        guard = 0;
        while (!o_Result_Valid && guard < 100) begin
            @(posedge i_Clock);
            #1;
            guard++;
        end
        check("bp_valid_seen", {31'b0, o_Result_Valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_Clock);
            i_Valid = 1'b1; i_Alu_Select = ALU_OP_ADD; i_Input_A = $urandom; i_Input_B = $urandom;
            @(posedge i_Clock);
            #1;
            check("bp_result", o_Alu_Result, 32'd14);
            check("bp_valid", {31'b0, o_Result_Valid}, 32'd1);
            check("bp_ready", {31'b0, o_Ready}, 32'd0);
        end
        @(negedge i_Clock);
        i_Valid = 1'b0;
        i_Result_Ready = 1'b1;
        @(posedge i_Clock);
        #1;
        i_Result_Ready = 1'b0;
        check("bp_release_ready", {31'b0, o_Ready}, 32'd1);
        check("bp_release_valid", {31'b0, o_Result_Valid}, 32'd0);
        @(negedge i_Clock);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = op_list[$urandom_range(0, 18)];
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, res, lat);
            check($sformatf("rnd%0d_op%0h_res", n, op), res, ref_result(op, a, b));
            check($sformatf("rnd%0d_op%0h_lat", n, op), 32'(lat), 32'(ref_latency(op, a, b)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
